// File: rtl/serv_wfi_seq.sv
// -----------------------------------------------------------------------------
// serv_wfi_seq
//
// Sequences a WFI on the side that starts the sleep/halt handshake. It takes a
// WFI request from the core and waits for outstanding bus traffic to drain.
// It then holds o_sleep_request to the clock-halt block until an interrupt
// arrives. After wake it waits a settle delay and completes the WFI back to
// the core. Runs on the free-running (ungated) clock.
//
// Parameters
//   RESET_STRATEGY  "NONE" resets only the FSM state; any other value also
//                   resets the counter and the abort flag
//   WAKE_DELAY      settle cycles spent in WAKE before completion (0 = none)
//   DRAIN_TIMEOUT   max DRAIN cycles before aborting (0 = wait forever)
//
// Ports
//   i_clk            in   1   free-running clock
//   i_rst            in   1   synchronous, active-high reset
//   i_wfi_valid      in   1   core WFI request, held until o_wfi_ready
//   i_bus_idle       in   1   no outstanding ibus/dbus transactions
//   i_timer_irq      in   1   timer interrupt pending
//   i_external_irq   in   1   external interrupt pending
//   o_sleep_request  out  1   clock-halt request, high only in SLEEP
//   o_wfi_ready      out  1   one-cycle WFI completion strobe
//   o_wfi_abort      out  1   with o_wfi_ready: WFI ended without sleeping
//   o_sleeping       out  1   high in SLEEP or WAKE
//   o_sleep_cycles   out  32  saturating count of SLEEP cycles
//                             (only when SERV_WFI_STATS_EN is defined)
//
// Build option
//   SERV_WFI_STATS_EN  adds o_sleep_cycles and its counter
// -----------------------------------------------------------------------------
module serv_wfi_seq #(
   parameter              RESET_STRATEGY = "MINI",
   parameter int unsigned WAKE_DELAY     = 4,
   parameter int unsigned DRAIN_TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wfi_valid,
   input  logic        i_bus_idle,
   input  logic        i_timer_irq,
   input  logic        i_external_irq,
   output logic        o_sleep_request,
   output logic        o_wfi_ready,
   output logic        o_wfi_abort,
   output logic        o_sleeping
`ifdef SERV_WFI_STATS_EN
   ,
   output logic [31:0] o_sleep_cycles
`endif
);

   localparam bit          RESET_ALL  = (RESET_STRATEGY != "NONE");
   localparam int unsigned CNT_MAX    = (WAKE_DELAY > DRAIN_TIMEOUT) ? WAKE_DELAY : DRAIN_TIMEOUT;
   localparam int unsigned CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam int unsigned DRAIN_LAST = (DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1;
   localparam int unsigned WAKE_LAST  = (WAKE_DELAY == 0) ? 0 : WAKE_DELAY - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_SLEEP,
      S_WAKE,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             abort_q;
   logic             abort_nxt;
   logic             wake;

   assign wake = i_timer_irq | i_external_irq;

   // NOTE: every variable gets its hold value first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      abort_nxt = abort_q;
      case (state)
         S_IDLE: begin
            if (i_wfi_valid) begin
               if (wake) begin
                  state_nxt = S_DONE;
                  abort_nxt = 1'b1;
               end else begin
                  state_nxt = S_DRAIN;
                  cnt_nxt   = '0;
                  abort_nxt = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            // Wake beats bus idle, which beats the drain timeout.
            if (wake) begin
               state_nxt = S_DONE;
               abort_nxt = 1'b1;
            end else if (i_bus_idle) begin
               state_nxt = S_SLEEP;
            end else if ((DRAIN_TIMEOUT != 0) && (cnt == CNT_W'(DRAIN_LAST))) begin
               state_nxt = S_DONE;
               abort_nxt = 1'b1;
            end else if (cnt != '1) begin
               // Saturate rather than wrap when waiting forever.
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_SLEEP: begin
            if (wake) begin
               abort_nxt = 1'b0;
               cnt_nxt   = '0;
               state_nxt = (WAKE_DELAY == 0) ? S_DONE : S_WAKE;
            end
         end
         S_WAKE: begin
            // Settle delay runs to completion even if the interrupt drops.
            if (cnt == CNT_W'(WAKE_LAST)) begin
               state_nxt = S_DONE;
               abort_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: state is held in flops written only with non-blocking assignments,
   // so every flop samples the pre-edge values of its peers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: the counter and abort flag are fully rewritten before they are
   // read, so under "NONE" they are deliberately left out of reset.
   always_ff @(posedge i_clk) begin
      cnt     <= cnt_nxt;
      abort_q <= abort_nxt;
      if (RESET_ALL && i_rst) begin
         cnt     <= '0;
         abort_q <= 1'b0;
      end
   end

   assign o_sleep_request = (state == S_SLEEP);
   assign o_sleeping      = (state == S_SLEEP) || (state == S_WAKE);
   assign o_wfi_ready     = (state == S_DONE);
   assign o_wfi_abort     = (state == S_DONE) && abort_q;

`ifdef SERV_WFI_STATS_EN
   logic [31:0] sleep_cycles;

   // Always reset, independent of RESET_STRATEGY, so software sees a clean count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sleep_cycles <= '0;
      end else if ((state == S_SLEEP) && (sleep_cycles != 32'hFFFF_FFFF)) begin
         sleep_cycles <= sleep_cycles + 32'd1;
      end
   end

   assign o_sleep_cycles = sleep_cycles;
`endif

endmodule

// File: tb/tb_serv_wfi_seq.sv
`timescale 1ns/1ps
module tb_serv_wfi_seq;

   localparam int WD = 4;
   localparam int DT = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Main instance: default parameters.
   logic valid = 1'b0, bus_idle = 1'b0, tirq = 1'b0, eirq = 1'b0;
   logic sleep_req, ready, abort, sleeping;

   // Second instance: no settle delay, no drain timeout, minimal reset.
   logic v0 = 1'b0, idle0 = 1'b0, t0 = 1'b0, e0 = 1'b0;
   logic sleep_req0, ready0, abort0, sleeping0;

`ifdef SERV_WFI_STATS_EN
   logic [31:0] sleep_cycles, sleep_cycles0;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serv_wfi_seq #(
      .RESET_STRATEGY("MINI"),
      .WAKE_DELAY    (WD),
      .DRAIN_TIMEOUT (DT)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wfi_valid    (valid),
      .i_bus_idle     (bus_idle),
      .i_timer_irq    (tirq),
      .i_external_irq (eirq),
      .o_sleep_request(sleep_req),
      .o_wfi_ready    (ready),
      .o_wfi_abort    (abort),
      .o_sleeping     (sleeping)
`ifdef SERV_WFI_STATS_EN
      ,
      .o_sleep_cycles (sleep_cycles)
`endif
   );

   serv_wfi_seq #(
      .RESET_STRATEGY("NONE"),
      .WAKE_DELAY    (0),
      .DRAIN_TIMEOUT (0)
   ) dut0 (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_wfi_valid    (v0),
      .i_bus_idle     (idle0),
      .i_timer_irq    (t0),
      .i_external_irq (e0),
      .o_sleep_request(sleep_req0),
      .o_wfi_ready    (ready0),
      .o_wfi_abort    (abort0),
      .o_sleeping     (sleeping0)
`ifdef SERV_WFI_STATS_EN
      ,
      .o_sleep_cycles (sleep_cycles0)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Reference model of the main instance: tracks which phase of the WFI the
   // core is in, with a countdown of settle cycles and a tally of drain cycles.
   // ---------------------------------------------------------------------------
   typedef enum int {PH_IDLE, PH_DRAIN, PH_ASLEEP, PH_SETTLE, PH_DONE} phase_t;

   phase_t m_phase       = PH_IDLE;
   int     m_drained     = 0;
   int     m_settle_left = 0;
   bit     m_aborted     = 1'b0;
   longint m_sleep_total = 0;
   bit     m_live        = 1'b0;

   function automatic void m_finish(input bit aborted);
      m_phase   = PH_DONE;
      m_aborted = aborted;
   endfunction

   always @(posedge clk) begin
      bit w;
      w = tirq | eirq;
      if (rst) begin
         m_sleep_total = 0;
      end else if (m_phase == PH_ASLEEP && m_sleep_total < 64'hFFFF_FFFF) begin
         m_sleep_total = m_sleep_total + 1;
      end
      if (rst) begin
         m_phase = PH_IDLE;
      end else begin
         case (m_phase)
            PH_IDLE:
               if (valid) begin
                  if (w) m_finish(1'b1);
                  else begin
                     m_phase   = PH_DRAIN;
                     m_drained = 0;
                  end
               end
            PH_DRAIN: begin
               m_drained = m_drained + 1;
               if (w) m_finish(1'b1);
               else if (bus_idle) m_phase = PH_ASLEEP;
               else if (DT != 0 && m_drained >= DT) m_finish(1'b1);
            end
            PH_ASLEEP:
               if (w) begin
                  if (WD == 0) m_finish(1'b0);
                  else begin
                     m_phase       = PH_SETTLE;
                     m_settle_left = WD;
                  end
               end
            PH_SETTLE: begin
               m_settle_left = m_settle_left - 1;
               if (m_settle_left == 0) m_finish(1'b0);
            end
            default: m_phase = PH_IDLE;
         endcase
      end
      m_live = 1'b1;
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_sleep_request", {31'd0, sleep_req}, {31'd0, m_phase == PH_ASLEEP});
         check("cyc_sleeping", {31'd0, sleeping},
               {31'd0, (m_phase == PH_ASLEEP) || (m_phase == PH_SETTLE)});
         check("cyc_wfi_ready", {31'd0, ready}, {31'd0, m_phase == PH_DONE});
         check("cyc_wfi_abort", {31'd0, abort}, {31'd0, (m_phase == PH_DONE) && m_aborted});
`ifdef SERV_WFI_STATS_EN
         check("cyc_sleep_cycles", sleep_cycles, m_sleep_total[31:0]);
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Directed scenarios. "cN" is the cycle index counted from the cycle in
   // which i_wfi_valid is first presented.
   // ---------------------------------------------------------------------------
   initial begin
      bit seen;

      rst = 1'b1;
      repeat (2) tick();
      check("reset_sleep_request", {31'd0, sleep_req}, 32'd0);
      check("reset_wfi_ready", {31'd0, ready}, 32'd0);
      check("reset_sleeping", {31'd0, sleeping}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: straight to sleep, timer wake in c11, completion in c16.
      valid = 1'b1;
      bus_idle = 1'b1;
      tick();
      check("s1_c1_draining", {31'd0, sleep_req}, 32'd0);
      tick();
      check("s1_c2_sleep_request", {31'd0, sleep_req}, 32'd1);
      repeat (9) tick();
      check("s1_c11_sleep_request", {31'd0, sleep_req}, 32'd1);
      tirq = 1'b1;
      tick();
      check("s1_c12_sleep_request", {31'd0, sleep_req}, 32'd0);
      check("s1_c12_sleeping", {31'd0, sleeping}, 32'd1);
      tirq = 1'b0;
      repeat (3) tick();
      check("s1_c15_not_ready", {31'd0, ready}, 32'd0);
      tick();
      check("s1_c16_ready", {31'd0, ready}, 32'd1);
      check("s1_c16_abort", {31'd0, abort}, 32'd0);
      check("s1_model_done", {31'd0, m_phase == PH_DONE}, 32'd1);
      valid = 1'b0;
      bus_idle = 1'b0;
      tick();
      check("s1_c17_ready_drop", {31'd0, ready}, 32'd0);

      // 2: interrupt already pending when WFI is requested.
      valid = 1'b1;
      eirq = 1'b1;
      tick();
      check("s2_c1_ready", {31'd0, ready}, 32'd1);
      check("s2_c1_abort", {31'd0, abort}, 32'd1);
      check("s2_c1_sleep_request", {31'd0, sleep_req}, 32'd0);
      check("s2_model_aborted", {31'd0, m_aborted}, 32'd1);
      valid = 1'b0;
      eirq = 1'b0;
      tick();

      // 3: bus never idles, drain timeout completes in c17.
      valid = 1'b1;
      bus_idle = 1'b0;
      seen = 1'b0;
      repeat (16) begin
         tick();
         seen = seen | ready | sleep_req;
      end
      check("s3_quiet_while_draining", {31'd0, seen}, 32'd0);
      tick();
      check("s3_c17_ready", {31'd0, ready}, 32'd1);
      check("s3_c17_abort", {31'd0, abort}, 32'd1);
      valid = 1'b0;
      tick();

      // 4: reset while asleep, then a normal WFI.
      valid = 1'b1;
      bus_idle = 1'b1;
      repeat (3) tick();
      check("s4_c3_sleep_request", {31'd0, sleep_req}, 32'd1);
      rst = 1'b1;
      valid = 1'b0;
      tick();
      check("s4_reset_sleep_request", {31'd0, sleep_req}, 32'd0);
      check("s4_reset_sleeping", {31'd0, sleeping}, 32'd0);
      rst = 1'b0;
      tick();
      valid = 1'b1;
      repeat (2) tick();
      check("s4_restart_sleep_request", {31'd0, sleep_req}, 32'd1);
      eirq = 1'b1;
      tick();
      eirq = 1'b0;
      repeat (WD) tick();
      check("s4_restart_ready", {31'd0, ready}, 32'd1);
      check("s4_restart_abort", {31'd0, abort}, 32'd0);
      valid = 1'b0;
      bus_idle = 1'b0;
      tick();

      // 5: no settle delay; a one-cycle irq in SLEEP completes the next cycle.
      v0 = 1'b1;
      idle0 = 1'b1;
      repeat (2) tick();
      check("s5_c2_sleep_request", {31'd0, sleep_req0}, 32'd1);
      repeat (2) tick();
      t0 = 1'b1;
      tick();
      t0 = 1'b0;
      check("s5_ready", {31'd0, ready0}, 32'd1);
      check("s5_abort", {31'd0, abort0}, 32'd0);
      check("s5_sleeping", {31'd0, sleeping0}, 32'd0);
      v0 = 1'b0;
      tick();
      check("s5_ready_drop", {31'd0, ready0}, 32'd0);

      // 5b: no drain timeout; waits well past 16 cycles, then an irq aborts.
      v0 = 1'b1;
      idle0 = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         tick();
         seen = seen | ready0 | sleep_req0;
      end
      check("s5b_still_draining", {31'd0, seen}, 32'd0);
      e0 = 1'b1;
      tick();
      check("s5b_ready", {31'd0, ready0}, 32'd1);
      check("s5b_abort", {31'd0, abort0}, 32'd1);
      e0 = 1'b0;
      v0 = 1'b0;
      tick();

`ifdef SERV_WFI_STATS_EN
      // 6: two sleeps of 7 and 5 SLEEP cycles.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("s6_cleared", sleep_cycles, 32'd0);
      valid = 1'b1;
      bus_idle = 1'b1;
      repeat (2) tick();
      repeat (6) tick();
      tirq = 1'b1;
      tick();
      tirq = 1'b0;
      check("s6_first_sleep", sleep_cycles, 32'd7);
      repeat (WD) tick();
      valid = 1'b0;
      tick();
      valid = 1'b1;
      repeat (2) tick();
      repeat (4) tick();
      tirq = 1'b1;
      tick();
      tirq = 1'b0;
      check("s6_total", sleep_cycles, 32'd12);
      repeat (WD) tick();
      valid = 1'b0;
      bus_idle = 1'b0;
      tick();
`endif

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
